// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the branch resolution unit: condition codes, flag bit
// positions, FSM states and the flag value that describes a zero result.
package branch_resolve_pkg;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_NE     = 3'd2;
  localparam logic [2:0] COND_LT     = 3'd3;
  localparam logic [2:0] COND_GT     = 3'd4;
  localparam logic [2:0] COND_LE     = 3'd5;
  localparam logic [2:0] COND_GE     = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  localparam int CC_EQ = 0;
  localparam int CC_LT = 1;
  localparam int CC_GT = 2;
  localparam int CC_LE = 3;
  localparam int CC_GE = 4;
  localparam int CC_NE = 5;

  localparam logic [5:0] CC_RST_FLAGS = 6'b011001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_CC = 2'd1,
    S_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational condition check: picks one flag bit per condition code,
// with ALWAYS/NEVER ignoring the flags.
module branch_resolve_cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [5:0] flags_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_ALWAYS: taken_o = 1'b1;
      COND_EQ:     taken_o = flags_i[CC_EQ];
      COND_NE:     taken_o = flags_i[CC_NE];
      COND_LT:     taken_o = flags_i[CC_LT];
      COND_GT:     taken_o = flags_i[CC_GT];
      COND_LE:     taken_o = flags_i[CC_LE];
      COND_GE:     taken_o = flags_i[CC_GE];
      COND_NEVER:  taken_o = 1'b0;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves conditional branches against the flags of the youngest older
// flag producer; emits a one-cycle registered taken/next-PC result.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cc_issue_i,
  input  logic          cc_valid_i,
  input  logic [5:0]    cc_flags_i,
  input  logic          br_valid_i,
  output logic          br_ready_o,
  input  logic [2:0]    br_cond_i,
  input  logic [AW-1:0] br_pc_i,
  input  logic [AW-1:0] br_offset_i,
  output logic          res_valid_o,
  output logic          res_taken_o,
  output logic [AW-1:0] res_pc_o,
  output logic          cc_err_o
);

  localparam logic [AW-1:0] PC_STEP = AW'(4);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [5:0]    flags_q, flags_d;
  logic          err_q, err_d;
  logic [2:0]    cond_q, cond_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] off_q, off_d;
  logic          res_valid_q, res_taken_q;
  logic [AW-1:0] res_pc_q;

  logic          older_vld, fire, sel_bypass, taken;
  logic [2:0]    eval_cond;
  logic [5:0]    eval_flags;
  logic [AW-1:0] base_pc, base_off, next_pc;

  // A cc_valid only belongs to an older producer if one is outstanding.
  assign older_vld = cc_valid_i && (cnt_q != 2'd0);

  always_comb begin
    cnt_d   = cnt_q;
    flags_d = flags_q;
    err_d   = err_q;
    if (cc_valid_i && cc_issue_i) begin
      flags_d = cc_flags_i;
    end else if (cc_valid_i) begin
      if (cnt_q == 2'd0) begin
        err_d = 1'b1;
      end else begin
        cnt_d   = cnt_q - 2'd1;
        flags_d = cc_flags_i;
      end
    end else if (cc_issue_i) begin
      if (cnt_q == 2'd3) err_d = 1'b1;
      else               cnt_d = cnt_q + 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    cond_d     = cond_q;
    pc_d       = pc_q;
    off_d      = off_q;
    fire       = 1'b0;
    sel_bypass = 1'b0;
    eval_cond  = cond_q;
    base_pc    = pc_q;
    base_off   = off_q;
    case (state_q)
      S_IDLE: begin
        if (br_valid_i) begin
          cond_d     = br_cond_i;
          pc_d       = br_pc_i;
          off_d      = br_offset_i;
          eval_cond  = br_cond_i;
          base_pc    = br_pc_i;
          base_off   = br_offset_i;
          wcnt_d     = cnt_q - {1'b0, older_vld};
          sel_bypass = older_vld;
          if (wcnt_d == 2'd0 || br_cond_i == COND_ALWAYS || br_cond_i == COND_NEVER)
            fire = 1'b1;
          else
            state_d = S_WAIT_CC;
        end
      end
      S_WAIT_CC: begin
        if (cc_valid_i) begin
          wcnt_d = wcnt_q - 2'd1;
          if (wcnt_q == 2'd1) begin
            fire       = 1'b1;
            sel_bypass = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fire) state_d = S_DONE;
  end

  assign eval_flags = sel_bypass ? cc_flags_i : flags_q;

  branch_resolve_cond_eval u_cond_eval (
    .cond_i  (eval_cond),
    .flags_i (eval_flags),
    .taken_o (taken)
  );

  assign next_pc = taken ? (base_pc + base_off) : (base_pc + PC_STEP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      wcnt_q      <= 2'd0;
      flags_q     <= CC_RST_FLAGS;
      err_q       <= 1'b0;
      cond_q      <= COND_ALWAYS;
      pc_q        <= '0;
      off_q       <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      cond_q      <= cond_d;
      pc_q        <= pc_d;
      off_q       <= off_d;
      res_valid_q <= fire;
      if (fire) begin
        res_taken_q <= taken;
        res_pc_q    <= next_pc;
      end
    end
  end

  assign br_ready_o  = (state_q == S_IDLE);
  assign res_valid_o = res_valid_q;
  assign res_taken_o = res_taken_q;
  assign res_pc_o    = res_pc_q;
  assign cc_err_o    = err_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a producer/branch model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_branch_resolve;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, cc_issue, cc_valid, br_valid;
  logic [5:0]    cc_flags;
  logic [2:0]    br_cond;
  logic [AW-1:0] br_pc, br_offset;
  logic          br_ready, res_valid, res_taken, cc_err;
  logic [AW-1:0] res_pc;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve #(.AW(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cc_issue_i  (cc_issue),
    .cc_valid_i  (cc_valid),
    .cc_flags_i  (cc_flags),
    .br_valid_i  (br_valid),
    .br_ready_o  (br_ready),
    .br_cond_i   (br_cond),
    .br_pc_i     (br_pc),
    .br_offset_i (br_offset),
    .res_valid_o (res_valid),
    .res_taken_o (res_taken),
    .res_pc_o    (res_pc),
    .cc_err_o    (cc_err)
  );

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: outstanding producer count, current flags, and one pending branch
  // that needs a given number of further flag deliveries.
  int            m_out;
  logic [5:0]    m_flags;
  bit            m_err, m_wait, cmp_en = 0;
  int            m_need;
  logic [2:0]    m_cond;
  logic [AW-1:0] m_pc, m_off;
  bit            e_valid, e_taken;
  logic [AW-1:0] e_pc;

  function automatic bit m_taken(input logic [2:0] c, input logic [5:0] f);
    int pos[8];
    pos = '{0, 0, 5, 1, 2, 3, 4, 0};  // EQ NE LT GT LE GE -> flag bit
    if (c == 3'd0) return 1'b1;
    if (c == 3'd7) return 1'b0;
    return f[pos[c]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_out = 0; m_flags = 6'b011001; m_err = 0; m_wait = 0; m_need = 0;
      e_valid = 0; e_taken = 0; e_pc = '0;
      cmp_en = 1;
    end else if (cmp_en) begin
      bit ready, older, fire;
      logic [5:0] fl;
      ready = !m_wait && !e_valid;
      older = cc_valid && (m_out > 0);
      fire  = 0;
      fl    = m_flags;
      if (m_wait && cc_valid) begin
        m_need--;
        if (m_need == 0) begin fire = 1; fl = cc_flags; m_wait = 0; end
      end
      if (ready && br_valid) begin
        m_cond = br_cond; m_pc = br_pc; m_off = br_offset;
        m_need = m_out - (older ? 1 : 0);
        if (m_need == 0 || br_cond == 3'd0 || br_cond == 3'd7) begin
          fire = 1; fl = older ? cc_flags : m_flags;
        end else m_wait = 1;
      end
      e_valid = fire;
      if (fire) begin
        e_taken = m_taken(m_cond, fl);
        e_pc    = e_taken ? m_pc + m_off : m_pc + 32'd4;
      end
      if (cc_valid && !cc_issue) begin
        if (m_out == 0) m_err = 1;
        else begin m_out--; m_flags = cc_flags; end
      end else if (cc_issue && !cc_valid) begin
        if (m_out == 3) m_err = 1;
        else m_out++;
      end else if (cc_issue && cc_valid) m_flags = cc_flags;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model br_ready",  br_ready,  !m_wait && !e_valid);
      chk("model res_valid", res_valid, e_valid);
      chk("model res_taken", res_taken, e_taken);
      chk("model res_pc",    res_pc,    e_pc);
      chk("model cc_err",    cc_err,    m_err);
    end
  end

  task automatic drive(input logic r, input logic iss, input logic vld, input logic [5:0] fl,
                       input logic bv, input logic [2:0] c,
                       input logic [AW-1:0] pc, input logic [AW-1:0] off);
    rst = r; cc_issue = iss; cc_valid = vld; cc_flags = fl;
    br_valid = bv; br_cond = c; br_pc = pc; br_offset = off;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 6'b0, 0, 3'd0, '0, '0);
  endtask

  task automatic issue();
    drive(0, 1, 0, 6'b0, 0, 3'd0, '0, '0);
  endtask

  task automatic ccv(input logic [5:0] fl);
    drive(0, 0, 1, fl, 0, 3'd0, '0, '0);
  endtask

  initial begin
    drive(1, 0, 0, 6'b0, 0, 3'd0, '0, '0);
    drive(1, 0, 0, 6'b0, 0, 3'd0, '0, '0);
    chk("reset br_ready", br_ready, 1'b1);
    chk("reset res_valid", res_valid, 1'b0);
    chk("reset res_pc", res_pc, 32'h0);
    chk("reset cc_err", cc_err, 1'b0);

    // No-wait branch on reset flags
    drive(0, 0, 0, 6'b0, 1, 3'd1, 32'h100, 32'h20);
    chk("nowait valid", res_valid, 1'b1);
    chk("nowait taken", res_taken, 1'b1);
    chk("nowait pc", res_pc, 32'h120);
    chk("nowait ready", br_ready, 1'b0);
    idle();
    chk("nowait strobe once", res_valid, 1'b0);

    // Wait path: two outstanding producers
    issue(); issue();
    drive(0, 0, 0, 6'b0, 1, 3'd3, 32'h200, 32'hFFFF_FFF8);
    chk("wait ready", br_ready, 1'b0);
    chk("wait no result", res_valid, 1'b0);
    ccv(6'b101001);
    chk("wait first cc", res_valid, 1'b0);
    ccv(6'b101010);
    chk("wait valid", res_valid, 1'b1);
    chk("wait taken", res_taken, 1'b1);
    chk("wait pc", res_pc, 32'h1F8);
    idle();

    // Younger producer issued in the accept cycle is excluded
    issue();
    drive(0, 1, 0, 6'b0, 1, 3'd2, 32'h300, 32'h40);
    chk("younger wait", res_valid, 1'b0);
    ccv(6'b100110);
    chk("younger valid", res_valid, 1'b1);
    chk("younger taken", res_taken, 1'b1);
    chk("younger pc", res_pc, 32'h340);
    ccv(6'b000001);
    chk("younger no second", res_valid, 1'b0);
    idle();

    // Concurrent cc_valid at accept bypasses into the evaluation
    issue();
    drive(0, 0, 1, 6'b000100, 1, 3'd4, 32'h400, 32'h10);
    chk("simul valid", res_valid, 1'b1);
    chk("simul taken", res_taken, 1'b1);
    chk("simul pc", res_pc, 32'h410);
    idle();
    drive(0, 0, 0, 6'b0, 1, 3'd7, 32'h500, 32'h8);
    chk("never taken", res_taken, 1'b0);
    chk("never pc", res_pc, 32'h504);
    idle();

    // Wrap-around (flags now GT only)
    drive(0, 0, 0, 6'b0, 1, 3'd1, 32'hFFFF_FFFC, 32'h10);
    chk("wrap nt taken", res_taken, 1'b0);
    chk("wrap nt pc", res_pc, 32'h0);
    idle();
    drive(0, 0, 0, 6'b0, 1, 3'd4, 32'hFFFF_FFFC, 32'h10);
    chk("wrap t pc", res_pc, 32'hC);
    idle();

    // Stray cc_valid is ignored and flagged
    ccv(6'b111111);
    chk("stray err", cc_err, 1'b1);
    drive(0, 0, 0, 6'b0, 1, 3'd1, 32'h700, 32'h8);
    chk("stray flags kept", res_taken, 1'b0);
    chk("stray pc", res_pc, 32'h704);
    idle();

    // Reset clears error; counter saturates at 3
    drive(1, 0, 0, 6'b0, 0, 3'd0, '0, '0);
    chk("rst clears err", cc_err, 1'b0);
    issue(); issue(); issue();
    chk("three issues ok", cc_err, 1'b0);
    issue();
    chk("sat err", cc_err, 1'b1);
    drive(0, 0, 0, 6'b0, 1, 3'd1, 32'h600, 32'h20);
    ccv(6'b000000);
    ccv(6'b000000);
    chk("sat still waiting", res_valid, 1'b0);
    ccv(6'b000001);
    chk("sat valid", res_valid, 1'b1);
    chk("sat pc", res_pc, 32'h620);
    idle();

    // Reset while waiting abandons the branch
    issue();
    drive(0, 0, 0, 6'b0, 1, 3'd3, 32'h800, 32'h4);
    chk("abandon waiting", br_ready, 1'b0);
    drive(1, 0, 0, 6'b0, 0, 3'd0, '0, '0);
    chk("abandon ready", br_ready, 1'b1);
    chk("abandon err", cc_err, 1'b0);
    chk("abandon no valid", res_valid, 1'b0);
    ccv(6'b000010);
    chk("abandon stays dead", res_valid, 1'b0);
    chk("abandon cnt cleared", cc_err, 1'b1);
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit. It consumes the six condition-code flags (EQ, LT, GT, LE, GE, NE) produced from the ALU's compare-against-zero result, and decides whether a conditional branch is taken. It tracks outstanding flag-producing instructions so that a branch is always evaluated against the flags of the youngest producer older than the branch. It emits a one-cycle registered redirect result (taken bit plus next PC) to the fetch/PC logic.

## Interface
Parameters:
- AW, 32, PC/offset width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cc_issue  in  1  a flag-producing instruction issued this cycle
- cc_valid  in  1  flags of the oldest outstanding producer are present this cycle
- cc_flags  in  6  {NE,GE,LE,GT,LT,EQ}, bit0 = EQ
- br_valid  in  1  branch request
- br_ready  out  1  branch accepted when br_valid && br_ready
- br_cond  in  3  0 ALWAYS, 1 EQ, 2 NE, 3 LT, 4 GT, 5 LE, 6 GE, 7 NEVER
- br_pc  in  AW  branch PC
- br_offset  in  AW  signed byte offset
- res_valid  out  1  one-cycle result strobe
- res_taken  out  1  condition true
- res_pc  out  AW  next PC
- cc_err  out  1  sticky protocol error

Reset is synchronous and active-high. clk is the only clock.

## Operation
- Flag register `flags` is updated on every accepted cc_valid. Reset value is 6'b011001 (the flags for a zero value: EQ=1, LE=1, GE=1, all others 0).
- Outstanding counter `cnt` is 2 bits:
  - +1 on cc_issue, −1 on cc_valid; both in the same cycle leaves it unchanged.
  - cc_valid with cnt==0 and no cc_issue: ignored (flags not updated) and sets cc_err.
  - cc_issue with cnt==3 and no cc_valid: cnt saturates and sets cc_err.
  - cc_err clears only on rst.
- FSM states: IDLE, WAIT_CC, DONE.
  - IDLE: br_ready=1. On accept, capture br_cond, br_pc and br_offset, and snapshot `wcnt` = cnt (the pre-update value).
    - A cc_issue in the accept cycle belongs to a younger instruction and is excluded from `wcnt`.
    - A cc_valid in the accept cycle belongs to an older producer. In that case `wcnt` = cnt−1, and the incoming cc_flags are used in place of `flags`.
    - If `wcnt`==0, or cond is ALWAYS or NEVER: evaluate now and go to DONE.
    - Otherwise go to WAIT_CC.
  - WAIT_CC: br_ready=0. Each cc_valid decrements `wcnt`. The cc_valid that takes `wcnt` from 1 to 0 evaluates the condition against that cycle's cc_flags (bypass), then goes to DONE.
  - DONE: res_valid=1 for exactly this cycle, br_ready=0. Next state is IDLE unconditionally.
- Condition evaluation:
  - ALWAYS gives 1 and NEVER gives 0.
  - Every other code selects its single flag bit.
- Next-PC arithmetic:
  - res_pc = taken ? br_pc + br_offset : br_pc + 4.
  - Computed modulo 2^AW, so wrap-around is silent.
- res_taken and res_pc are registered on the transition into DONE and hold until the next result.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, wcnt = 0, flags = 6'b011001.
  - br_ready = 1 in the cycle after rst deasserts.
  - res_valid = 0, res_taken = 0, res_pc = 0, cc_err = 0.
- Latency without waiting: branch accepted at edge N, res_valid high in cycle N+1. Throughput is one branch per 2 cycles.
- Latency with waiting: res_valid is high in the cycle after the edge that samples the final cc_valid.
- rst mid-operation (in WAIT_CC or DONE) abandons the branch. No res_valid follows, and all state returns to its reset values.
- cc_issue and cc_valid are honoured in every state, including DONE and the accept cycle.

## Structure
- Shared package holds:
  - the br_cond encoding constants (COND_ALWAYS … COND_NEVER);
  - the flag bit indices (CC_EQ=0 … CC_NE=5);
  - the state enum;
  - the reset flag constant 6'b011001.
- One natural sub-module is `cond_eval`: combinational, cond[2:0] × flags[6] → taken. It is instantiated once and fed by a mux that selects `flags` or the bypassed cc_flags.
- The remaining logic (counter, FSM, PC adder, output registers) lives in the top module.

## Test plan
- **No-wait branch:** reset, then br_valid with cond=EQ, pc=0x100, offset=0x20, cnt=0 → res_valid in the next cycle, taken=1, res_pc=0x120 (reset flags have EQ=1).
- **Wait path:**
  - cc_issue twice, then a branch with cond=LT, pc=0x200, offset=−8 → FSM enters WAIT_CC.
  - cc_valid with flags=6'b101001 → no result yet.
  - cc_valid with flags=6'b101010 → res_valid in the next cycle, taken=1, res_pc=0x1F8.
- **Younger producer excluded:** cnt=1, branch NE accepted in the same cycle as cc_issue → resolves on the first cc_valid (flags=6'b100110), taken=1. The second cc_valid does not produce another result.
- **Simultaneous events:** at accept, cnt=1 with a concurrent cc_valid (flags GT=1), cond=GT → no wait, taken=1, res_pc=pc+offset. A cond=NEVER branch → taken=0, res_pc=pc+4.
- **Wrap-around:** pc=0xFFFFFFFC, not taken → res_pc=0x00000000. Taken with offset=0x10 → res_pc=0x0000000C.
- **Errors and reset:**
  - cc_valid with cnt=0 → cc_err=1 and flags unchanged.
  - Four cc_issue with no cc_valid → cnt stays 3 and cc_err=1.
  - rst asserted while in WAIT_CC → no res_valid, br_ready=1 after reset, cc_err=0.
